// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter driving the select of a shared 4-input mux
module mux4_rr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int NB_SELECT = 2,
  parameter int TIMEOUT   = 16,
  parameter int NB_COUNT  = 5
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [N_REQ-1:0]     i_request,
  input  logic                 i_done,
  output logic [N_REQ-1:0]     o_grant,
  output logic [NB_SELECT-1:0] o_select,
  output logic                 o_busy,
  output logic                 o_timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Counter value seen on the last permitted grant cycle.
  localparam logic [NB_COUNT-1:0] TERM = (TIMEOUT == 0) ? '0 : NB_COUNT'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [NB_COUNT-1:0]  count_q, count_d;
  logic [NB_SELECT-1:0] sel_q, sel_d;
  logic [NB_SELECT-1:0] last_q, last_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic                 timeout_q, timeout_d;
  logic [NB_SELECT-1:0] winner;
  logic                 found;
  logic                 wd_hit;

  always_comb begin
    winner = last_q;
    found  = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      if (!found && i_request[last_q + NB_SELECT'(off)]) begin
        winner = last_q + NB_SELECT'(off);
        found  = 1'b1;
      end
    end
  end

  assign wd_hit = (TIMEOUT != 0) && (count_q == TERM);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sel_d     = sel_q;
    last_d    = last_q;
    grant_d   = grant_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          grant_d = N_REQ'(1) << winner;
          sel_d   = winner;
          last_d  = winner;
          count_d = '0;
        end
      end
      BUSY: begin
        // Saturation keeps the free-running count harmless when the watchdog is off.
        count_d = (&count_q) ? count_q : count_q + 1'b1;
        if (i_done || !i_request[sel_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (wd_hit) begin
          state_d   = IDLE;
          grant_d   = '0;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      sel_q     <= '0;
      last_q    <= NB_SELECT'(N_REQ - 1);
      grant_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_grant   = grant_q;
  assign o_select  = sel_q;
  assign o_busy    = (state_q == BUSY);
  assign o_timeout = timeout_q;

  a_grant_onehot0: assert property (@(posedge i_clock) disable iff (!i_reset) $onehot0(o_grant));
  a_grant_busy:    assert property (@(posedge i_clock) disable iff (!i_reset) ((o_grant != '0) == o_busy));
  a_grant_select:  assert property (@(posedge i_clock) disable iff (!i_reset) (o_busy |-> o_grant[o_select]));

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - vector table, corner sequences and randomized model comparison
module tb_mux4_rr_arbiter;

  localparam int TMO = 16;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b0;
  logic [3:0] i_request = '0;
  logic       i_done = 1'b0;
  logic [3:0] o_grant;
  logic [1:0] o_select;
  logic       o_busy;
  logic       o_timeout;

  int checks = 0;
  int failures = 0;

  mux4_rr_arbiter #(.N_REQ(4), .NB_SELECT(2), .TIMEOUT(TMO), .NB_COUNT(5)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_request(i_request), .i_done(i_done),
    .o_grant(o_grant), .o_select(o_select), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
    logic       t;
  } vec_t;

  vec_t tbl[$];

  // Reference: grant owner, rotating pointer, and elapsed grant length in cycles.
  int m_busy, m_sel, m_last, m_len, m_to;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] req, input logic done,
                     input logic [3:0] g, input logic [1:0] s, input logic b, input logic t);
    vec_t v;
    v.rst = rst; v.req = req; v.done = done; v.g = g; v.s = s; v.b = b; v.t = t;
    tbl.push_back(v);
  endtask

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_last = 3; m_len = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d);
    int c;
    bit hit;
    m_to = 0;
    if (m_busy == 0) begin
      hit = 0;
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (!hit && r[c]) begin
          hit = 1; m_busy = 1; m_sel = c; m_last = c; m_len = 1;
        end
      end
    end else if (d) begin
      m_busy = 0;
    end else if (!r[m_sel]) begin
      m_busy = 0;
    end else if (TMO != 0 && m_len == TMO) begin
      m_busy = 0; m_to = 1;
    end else begin
      m_len++;
    end
  endtask

  // Called at a negedge; returns at the next negedge with the edge's results visible.
  task automatic step(input logic [3:0] r, input logic d);
    i_request = r;
    i_done = d;
    model_step(r, d);
    @(posedge i_clock);
    @(negedge i_clock);
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    i_request = '0;
    i_done = 1'b0;
    @(posedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b1;
    model_reset();
  endtask

  initial begin
    int len, n, tseen;
    logic [3:0] rq;
    logic dn;
    model_reset();
    @(negedge i_clock);
    chk("reset_grant", o_grant, 0);
    chk("reset_select", o_select, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_timeout", o_timeout, 0);
    i_reset = 1'b1;

    // Single requester 2, done during the fourth BUSY cycle.
    add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0100, 0, 4'b0100, 2, 1, 0);
    add(0, 4'b0100, 0, 4'b0100, 2, 1, 0);
    add(0, 4'b0100, 0, 4'b0100, 2, 1, 0);
    add(0, 4'b0100, 0, 4'b0100, 2, 1, 0);
    add(0, 4'b0100, 1, 4'b0000, 2, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 2, 0, 0);
    // All four requesting, done every BUSY cycle: 0,1,2,3,0 with gaps.
    add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, 0, 4'b0001, 0, 1, 0);
    add(0, 4'b1111, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, 0, 4'b0010, 1, 1, 0);
    add(0, 4'b1111, 1, 4'b0000, 1, 0, 0);
    add(0, 4'b1111, 0, 4'b0100, 2, 1, 0);
    add(0, 4'b1111, 1, 4'b0000, 2, 0, 0);
    add(0, 4'b1111, 0, 4'b1000, 3, 1, 0);
    add(0, 4'b1111, 1, 4'b0000, 3, 0, 0);
    add(0, 4'b1111, 0, 4'b0001, 0, 1, 0);
    add(0, 4'b1111, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) begin
        do_reset();
      end else begin
        step(tbl[i].req, tbl[i].done);
      end
      chk($sformatf("vec%0d_grant", i), o_grant, tbl[i].g);
      chk($sformatf("vec%0d_select", i), o_select, tbl[i].s);
      chk($sformatf("vec%0d_busy", i), o_busy, tbl[i].b);
      chk($sformatf("vec%0d_timeout", i), o_timeout, tbl[i].t);
    end

    // Watchdog: requester 0 held with no done.
    do_reset();
    step(4'b0001, 0);
    chk("wd_first_grant", o_grant, 4'b0001);
    len = 1; n = 0; tseen = 0;
    while (o_busy && n < 40) begin
      step(4'b0001, 0);
      n++;
      if (o_busy) len++;
      if (o_busy && o_timeout) tseen++;
    end
    chk("wd_grant_len", len, TMO);
    chk("wd_early_timeout", tseen, 0);
    chk("wd_timeout_pulse", o_timeout, 1);
    chk("wd_gap_busy", o_busy, 0);
    step(4'b0001, 0);
    chk("wd_regrant", o_grant, 4'b0001);
    chk("wd_pulse_end", o_timeout, 0);

    // Done on the terminal-count cycle wins over the watchdog.
    do_reset();
    step(4'b0001, 0);
    for (int i = 0; i < TMO - 1; i++) step(4'b0001, 0);
    chk("tc_still_busy", o_busy, 1);
    step(4'b0001, 1);
    chk("tc_exit_busy", o_busy, 0);
    chk("tc_no_timeout", o_timeout, 0);

    // Abort: requester 1 drops on its second BUSY cycle while 3 waits.
    do_reset();
    step(4'b0010, 0);
    chk("ab_grant1", o_grant, 4'b0010);
    step(4'b1010, 0);
    chk("ab_hold", o_grant, 4'b0010);
    step(4'b1000, 0);
    chk("ab_exit_grant", o_grant, 0);
    chk("ab_no_timeout", o_timeout, 0);
    chk("ab_sel_held", o_select, 1);
    step(4'b1000, 0);
    chk("ab_next_grant", o_grant, 4'b1000);
    chk("ab_next_sel", o_select, 3);

    // Asynchronous reset in the middle of a grant to requester 2.
    do_reset();
    step(4'b0100, 0);
    step(4'b0100, 0);
    chk("ar_pre_grant", o_grant, 4'b0100);
    #1 i_reset = 1'b0;
    #1;
    chk("ar_grant", o_grant, 0);
    chk("ar_busy", o_busy, 0);
    chk("ar_select", o_select, 0);
    @(negedge i_clock);
    i_reset = 1'b1;
    model_reset();
    step(4'b1111, 0);
    chk("ar_first_grant", o_grant, 4'b0001);

    // Randomized traffic against the reference model.
    do_reset();
    rq = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 2) rq = 4'($urandom);
      dn = ($urandom_range(0, 9) == 0);
      step(rq, dn);
      chk("rnd_grant", o_grant, m_busy ? (1 << m_sel) : 0);
      chk("rnd_select", o_select, m_sel);
      chk("rnd_busy", o_busy, m_busy);
      chk("rnd_timeout", o_timeout, m_to);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
